dvp_pattern_tx: RTL

DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

---
 rtl/dvp_pattern_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dvp_pattern_tx.sv
// DVP camera byte-stream transmitter with built-in RGB565 test patterns.
// Each sysclk cycle carries one DVP byte; every pixel takes two cycles, high byte first.
// Frame layout: VSYNC -> VBACK -> ACTIVE -> VFRONT, all built from lines of equal length.
module dvp_pattern_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic        sysclk,
    input  logic        sysrst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_db,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned LineLen  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned BarWidth = H_ACTIVE / 8;

    localparam logic [15:0] LastCol     = 16'(LineLen - 1);
    localparam logic [15:0] ActBytes    = 16'(2 * H_ACTIVE);
    localparam logic [15:0] BarW        = 16'(BarWidth);
    localparam logic [15:0] LastVsync   = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] LastVback   = 16'(V_BACK - 1);
    localparam logic [15:0] LastActive  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] LastVfront  = 16'(V_FRONT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    // Position of the current byte slot: state, byte column in the line, line within the state.
    state_e      state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] line_q, line_d;

    // Frame-wide pattern configuration, captured once per frame.
    logic [1:0]  pat_sel_q, pat_sel_d;
    logic [15:0] solid_q, solid_d;

    // Registered DVP outputs.
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  db_q, db_d;
    logic        fstart_q, fstart_d;
    logic        fdone_q, fdone_d;
    logic        busy_q, busy_d;

    logic [15:0] last_line;
    logic        first_vsync;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] bar_full;
    logic [15:0] pixel;
    logic        unused_bits;

    // Number of the last line belonging to the current state.
    always_comb begin
        last_line = 16'd0;
        case (state_q)
            StVsync:  last_line = LastVsync;
            StVback:  last_line = LastVback;
            StActive: last_line = LastActive;
            StVfront: last_line = LastVfront;
            default:  last_line = 16'd0;
        endcase
    end

    // Advance the byte/line position and walk the frame states.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        if (state_q == StIdle) begin
            col_d  = 16'd0;
            line_d = 16'd0;
            if (enable) begin
                state_d = StVsync;
            end
        end else if (col_q != LastCol) begin
            col_d = col_q + 16'd1;
        end else begin
            col_d = 16'd0;
            if (line_q != last_line) begin
                line_d = line_q + 16'd1;
            end else begin
                line_d = 16'd0;
                case (state_q)
                    StVsync:  state_d = StVback;
                    StVback:  state_d = StActive;
                    StActive: state_d = StVfront;
                    // Only the end of the front porch decides whether streaming continues.
                    StVfront: state_d = enable ? StVsync : StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    // Capture pattern configuration during the first VSYNC cycle of each frame.
    always_comb begin
        first_vsync = (state_q == StVsync) && (col_q == 16'd0) && (line_q == 16'd0);
        pat_sel_d   = first_vsync ? pattern_sel : pat_sel_q;
        solid_d     = first_vsync ? solid_color : solid_q;
    end

    // Pattern generator, evaluated for the byte slot that the next edge will present.
    always_comb begin
        pix_x    = {1'b0, col_d[15:1]};
        pix_y    = line_d;
        bar_full = pix_x / BarW;
        pixel    = 16'h0000;
        case (pat_sel_q)
            2'd0: begin
                case (bar_full[2:0])
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = {pix_x[5:1], pix_x[5:0], pix_x[5:1]};
            2'd2:    pixel = solid_q;
            default: pixel = (pix_x[5] ^ pix_y[5]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    // Bits of the coordinate arithmetic that no pattern looks at.
    assign unused_bits = ^{pix_x[15:6], pix_y[15:6], pix_y[4:0], bar_full[15:3]};

    // Output values for the upcoming slot, so every output leaves a flop.
    always_comb begin
        vsync_d  = (state_d == StVsync);
        href_d   = (state_d == StActive) && (col_d < ActBytes);
        db_d     = 8'h00;
        if (href_d) begin
            db_d = col_d[0] ? pixel[7:0] : pixel[15:8];
        end
        fstart_d = (state_d == StVsync) && (col_d == 16'd0) && (line_d == 16'd0);
        fdone_d  = (state_d == StVfront) && (col_d == LastCol) && (line_d == LastVfront);
        busy_d   = (state_d != StIdle);
    end

    // State, configuration and output registers; reset wins over everything.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_q   <= StIdle;
            col_q     <= 16'd0;
            line_q    <= 16'd0;
            pat_sel_q <= 2'd0;
            solid_q   <= 16'h0000;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            db_q      <= 8'h00;
            fstart_q  <= 1'b0;
            fdone_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            line_q    <= line_d;
            pat_sel_q <= pat_sel_d;
            solid_q   <= solid_d;
            vsync_q   <= vsync_d;
            href_q    <= href_d;
            db_q      <= db_d;
            fstart_q  <= fstart_d;
            fdone_q   <= fdone_d;
            busy_q    <= busy_d;
        end
    end

    assign cmos_vsync  = vsync_q;
    assign cmos_href   = href_q;
    assign cmos_db     = db_q;
    assign frame_start = fstart_q;
    assign frame_done  = fdone_q;
    assign busy        = busy_q;

endmodule
